// File: rtl/ibex_instr_mem_pkg.sv
// Shared types and limits for the instruction-memory responder.
package ibex_instr_mem_pkg;

  localparam int InstrMemMaxLatency = 8;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } instr_resp_t;

  // Misaligned, or outside [base, base+mem_bytes). The offset is an unsigned
  // 32-bit difference, so an address below base wraps high and fails too.
  function automatic logic instr_addr_err(input logic [1:0]  addr_lo,
                                          input logic [31:0] offset,
                                          input logic [31:0] mem_bytes);
    return (addr_lo != 2'b00) || (offset >= mem_bytes);
  endfunction

endpackage

// File: rtl/ibex_instr_mem_pipe.sv
// Fixed-depth response pipeline: one stage per cycle of fetch latency, no stalls.
module ibex_instr_mem_pipe
  import ibex_instr_mem_pkg::*;
#(
  parameter int Latency = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  instr_resp_t resp_i,
  output instr_resp_t resp_o
);

  logic [Latency-1:0] r_valid;
  logic [Latency-1:0] r_err;
  logic [31:0]        r_rdata [Latency];

  // Only the valid bits are reset; payload is qualified by valid downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= resp_i.valid;
      for (int i = 1; i < Latency; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    r_err[0]   <= resp_i.err;
    r_rdata[0] <= resp_i.rdata;
    for (int i = 1; i < Latency; i++) begin
      r_err[i]   <= r_err[i-1];
      r_rdata[i] <= r_rdata[i-1];
    end
  end

  assign resp_o = '{valid: r_valid[Latency-1],
                    err:   r_err[Latency-1],
                    rdata: r_rdata[Latency-1]};

endmodule

// File: rtl/ibex_instr_mem_resp.sv
// Instruction-fetch responder for ibex_core: word array, address check,
// outstanding-request accounting and a fixed-latency response pipeline.
module ibex_instr_mem_resp
  import ibex_instr_mem_pkg::*;
#(
  parameter logic [31:0] BaseAddr       = 32'h0001_0000,
  parameter int          MemWords       = 1024,
  parameter int          Latency        = 1,
  parameter int          MaxOutstanding = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                instr_req_i,
  input  logic [31:0]                         instr_addr_i,
  output logic                                instr_gnt_o,
  output logic                                instr_rvalid_o,
  output logic [31:0]                         instr_rdata_o,
  output logic                                instr_err_o,
  input  logic                                stall_i,
  input  logic                                load_we_i,
  input  logic [$clog2(MemWords)-1:0]         load_addr_i,
  input  logic [31:0]                         load_wdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);

  localparam int          IdxW     = $clog2(MemWords);
  localparam int          CntW     = $clog2(MaxOutstanding + 1);
  localparam logic [31:0] MemBytes = 32'(MemWords * 4);

  logic [31:0]     r_mem [MemWords];
  logic [CntW-1:0] r_outstanding;

  logic [CntW-1:0] w_cnt_after_resp;
  logic            w_gnt;
  logic            w_addr_err;
  logic [31:0]     w_offset;
  logic [IdxW-1:0] w_idx;
  instr_resp_t     w_resp_in;
  instr_resp_t     w_resp_out;

  // Handshake: a request transfers in any cycle where req and gnt are both
  // high; address may change freely while gnt is low. Each transfer yields
  // exactly one single-cycle rvalid, in order, with no ready/backpressure.
  assign w_cnt_after_resp = r_outstanding - CntW'(instr_rvalid_o);
  assign w_gnt = instr_req_i & ~stall_i &
                 (w_cnt_after_resp < CntW'(MaxOutstanding));

  assign w_offset   = instr_addr_i - BaseAddr;
  assign w_addr_err = instr_addr_err(instr_addr_i[1:0], w_offset, MemBytes);
  assign w_idx      = w_offset[IdxW+1:2];

  // Read happens in the grant cycle, before this edge's load write lands.
  always_comb begin
    w_resp_in       = '0;
    w_resp_in.valid = w_gnt;
    w_resp_in.err   = w_addr_err;
    if (!w_addr_err) begin
      w_resp_in.rdata = r_mem[w_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      r_mem[load_addr_i] <= load_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else begin
      unique case ({w_gnt, instr_rvalid_o})
        2'b10:   r_outstanding <= r_outstanding + CntW'(1);
        2'b01:   r_outstanding <= r_outstanding - CntW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  ibex_instr_mem_pipe #(
    .Latency (Latency)
  ) u_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .resp_i (w_resp_in),
    .resp_o (w_resp_out)
  );

  assign instr_gnt_o    = w_gnt;
  assign instr_rvalid_o = w_resp_out.valid;
  assign instr_err_o    = w_resp_out.valid & w_resp_out.err;
  assign instr_rdata_o  = (w_resp_out.valid & ~w_resp_out.err) ? w_resp_out.rdata : '0;
  assign outstanding_o  = r_outstanding;

endmodule

// File: tb/tb_ibex_instr_mem_resp.sv
// Bench for ibex_instr_mem_resp: two instances (Latency 1 and 3) share stimulus,
// each tracked by a due-time schedule model; directed tables cover the corners.
module tb_ibex_instr_mem_resp;

  localparam logic [31:0] Base     = 32'h0001_0000;
  localparam int          MemWords = 1024;
  localparam int          MaxOut   = 2;
  localparam int          Lat0     = 1;
  localparam int          Lat1     = 3;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_wdata;

  logic [1:0]  gnt_v;
  logic [1:0]  rvalid_v;
  logic [1:0]  err_v;
  logic [31:0] rdata_v [2];
  logic [1:0]  outst_v [2];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ibex_instr_mem_resp #(
    .BaseAddr(Base), .MemWords(MemWords), .Latency(Lat0), .MaxOutstanding(MaxOut)
  ) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt_v[0]), .instr_rvalid_o(rvalid_v[0]), .instr_rdata_o(rdata_v[0]),
    .instr_err_o(err_v[0]), .stall_i(stall), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_wdata_i(load_wdata), .outstanding_o(outst_v[0])
  );

  ibex_instr_mem_resp #(
    .BaseAddr(Base), .MemWords(MemWords), .Latency(Lat1), .MaxOutstanding(MaxOut)
  ) u_dut_l3 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt_v[1]), .instr_rvalid_o(rvalid_v[1]), .instr_rdata_o(rdata_v[1]),
    .instr_err_o(err_v[1]), .stall_i(stall), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_wdata_i(load_wdata), .outstanding_o(outst_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m [MemWords];
  int          cnt_m [2];
  logic        sch_v [2][16];
  logic        sch_e [2][16];
  logic [31:0] sch_d [2][16];
  int          cyc = 0;
  int          m_slot;
  int          m_due;
  logic        m_rv;
  logic        m_gnt;
  logic        m_bad;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < Base) || (a >= Base + 32'(4 * MemWords));
  endfunction

  function automatic logic [9:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - Base) / 4;
    return off[9:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rst_rvalid[%0d]", k), 32'(rvalid_v[k]), 32'd0);
        check($sformatf("rst_outstanding[%0d]", k), 32'(outst_v[k]), 32'd0);
        cnt_m[k] = 0;
        for (int s = 0; s < 16; s++) sch_v[k][s] = 1'b0;
      end
    end else begin
      m_slot = cyc % 16;
      for (int k = 0; k < 2; k++) begin
        m_rv  = sch_v[k][m_slot];
        m_gnt = req && !stall && ((cnt_m[k] - int'(m_rv)) < MaxOut);
        check($sformatf("m_gnt[%0d]", k), 32'(gnt_v[k]), 32'(m_gnt));
        check($sformatf("m_rvalid[%0d]", k), 32'(rvalid_v[k]), 32'(m_rv));
        check($sformatf("m_outstanding[%0d]", k), 32'(outst_v[k]), 32'(cnt_m[k]));
        if (m_rv) begin
          check($sformatf("m_err[%0d]", k), 32'(err_v[k]), 32'(sch_e[k][m_slot]));
          check($sformatf("m_rdata[%0d]", k), rdata_v[k], sch_d[k][m_slot]);
          sch_v[k][m_slot] = 1'b0;
          cnt_m[k]--;
        end
        if (m_gnt) begin
          m_bad = addr_bad(addr);
          m_due = (cyc + ((k == 0) ? Lat0 : Lat1)) % 16;
          sch_v[k][m_due] = 1'b1;
          sch_e[k][m_due] = m_bad;
          sch_d[k][m_due] = m_bad ? 32'd0 : mem_m[word_of(addr)];
          cnt_m[k]++;
        end
      end
    end
    if (load_we) mem_m[load_addr] = load_wdata;
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0; stall = 1'b0; load_we = 1'b0;
    repeat (n) tick();
  endtask

  task automatic load_word(input logic [9:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_wdata = d;
    tick();
    load_we = 1'b0;
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [31:0] addr;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } addr_vec_t;

  typedef struct {
    logic stall;
    logic exp_gnt;
    logic exp_rv_l3;
  } stall_vec_t;

  logic [31:0] prog [4];
  addr_vec_t   addr_tab [8];
  stall_vec_t  stall_tab [7];
  logic [5:0]  gnt_pat;
  int          r;

  initial begin
    prog[0] = 32'h00302503; prog[1] = 32'h05056593;
    prog[2] = 32'h00500613; prog[3] = 32'h014000ef;

    addr_tab[0] = '{32'h0000_FFFC, 1'b1, 32'h0};
    addr_tab[1] = '{32'h0001_1000, 1'b1, 32'h0};
    addr_tab[2] = '{32'h0001_0002, 1'b1, 32'h0};
    addr_tab[3] = '{32'h0001_0008, 1'b0, 32'h00500613};
    addr_tab[4] = '{32'h0000_0000, 1'b1, 32'h0};
    addr_tab[5] = '{32'hFFFF_FFFC, 1'b1, 32'h0};
    addr_tab[6] = '{32'h0001_0FFC, 1'b0, 32'h1234_5678};
    addr_tab[7] = '{32'h0001_0FFE, 1'b1, 32'h0};

    stall_tab[0] = '{1'b0, 1'b1, 1'b0};
    stall_tab[1] = '{1'b0, 1'b1, 1'b0};
    stall_tab[2] = '{1'b1, 1'b0, 1'b0};
    stall_tab[3] = '{1'b1, 1'b0, 1'b1};
    stall_tab[4] = '{1'b1, 1'b0, 1'b1};
    stall_tab[5] = '{1'b1, 1'b0, 1'b0};
    stall_tab[6] = '{1'b0, 1'b1, 1'b0};

    gnt_pat = 6'b110110;

    rst_n = 1'b0; req = 1'b0; addr = Base; stall = 1'b0;
    load_we = 1'b0; load_addr = '0; load_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state seen from the bench directly
    sample();
    for (int k = 0; k < 2; k++) begin
      check("reset_gnt", 32'(gnt_v[k]), 32'd0);
      check("reset_rdata", rdata_v[k], 32'd0);
      check("reset_err", 32'(err_v[k]), 32'd0);
    end
    tick();

    // defined contents everywhere, then the program and fixed words
    for (int i = 0; i < MemWords; i++) load_word(10'(i), $urandom);
    for (int i = 0; i < 4; i++) load_word(10'(i), prog[i]);
    load_word(10'd1023, 32'h1234_5678);
    load_word(10'd5, 32'h00b007b3);

    // sequential fetch at Latency 1: one grant per cycle, data one cycle later
    req = 1'b1; addr = Base;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) req = 1'b0;
      sample();
      if (i < 4) check("seq_gnt", 32'(gnt_v[0]), 32'd1);
      check("seq_rvalid", 32'(rvalid_v[0]), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) begin
        check("seq_rdata", rdata_v[0], prog[i-1]);
        check("seq_err", 32'(err_v[0]), 32'd0);
      end
      tick();
      addr = addr + 32'd4;
    end
    idle(10);

    // Latency 3 with two outstanding: grant pattern 1,1,0 repeating
    req = 1'b1; addr = Base;
    for (int i = 0; i < 6; i++) begin
      sample();
      check("l3_gnt_pattern", 32'(gnt_v[1]), 32'(gnt_pat[5-i]));
      check("l3_outst_le_max", 32'(outst_v[1] <= 2'd2), 32'd1);
      tick();
    end
    idle(10);

    // stall for 4 cycles while two are outstanding
    addr = Base + 32'd8;
    for (int i = 0; i < 7; i++) begin
      req = 1'b1; stall = stall_tab[i].stall;
      sample();
      check("stall_gnt_l3", 32'(gnt_v[1]), 32'(stall_tab[i].exp_gnt));
      check("stall_gnt_l1", 32'(gnt_v[0]), 32'(stall_tab[i].exp_gnt));
      check("stall_rvalid_l3", 32'(rvalid_v[1]), 32'(stall_tab[i].exp_rv_l3));
      tick();
    end
    idle(10);

    // address check vectors on the Latency 1 instance
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; addr = addr_tab[i].addr;
      sample();
      check("addr_gnt", 32'(gnt_v[0]), 32'd1);
      tick();
      req = 1'b0;
      sample();
      check("addr_rvalid", 32'(rvalid_v[0]), 32'd1);
      check("addr_err", 32'(err_v[0]), 32'(addr_tab[i].exp_err));
      check("addr_rdata", rdata_v[0], addr_tab[i].exp_rdata);
      tick();
    end
    idle(10);

    // write and fetch of the same word in one cycle returns the old word
    req = 1'b1; addr = Base + 32'd20;
    load_we = 1'b1; load_addr = 10'd5; load_wdata = 32'hDEADBEEF;
    sample();
    check("rbw_gnt", 32'(gnt_v[0]), 32'd1);
    tick();
    req = 1'b0; load_we = 1'b0;
    sample();
    check("rbw_old", rdata_v[0], 32'h00b007b3);
    tick();
    req = 1'b1;
    sample();
    tick();
    req = 1'b0;
    sample();
    check("rbw_new", rdata_v[0], 32'hDEADBEEF);
    tick();
    idle(10);

    // reset with two responses in flight on the Latency 3 instance
    req = 1'b1; addr = Base;
    sample();
    tick();
    sample();
    check("rst_pre_outst", 32'(outst_v[1]), 32'd1);
    tick();
    req = 1'b0; rst_n = 1'b0;
    sample();
    check("rst_mid_outst", 32'(outst_v[1]), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      check("rst_no_rvalid_l3", 32'(rvalid_v[1]), 32'd0);
      check("rst_no_rvalid_l1", 32'(rvalid_v[0]), 32'd0);
      tick();
    end
    req = 1'b1; addr = Base + 32'd20;
    tick();
    req = 1'b0;
    sample();
    check("rst_mem_kept_w5", rdata_v[0], 32'hDEADBEEF);
    tick();
    req = 1'b1; addr = Base + 32'd4;
    tick();
    req = 1'b0;
    sample();
    check("rst_mem_kept_w1", rdata_v[0], prog[1]);
    tick();
    idle(10);

    // randomized traffic, checked by the schedule model
    for (int i = 0; i < 600; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 11);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = Base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      else if (r == 2) addr = Base + 32'(4 * MemWords);
      else if (r == 3) addr = Base - 32'd4;
      else if (r == 4) addr = Base + 32'(4 * $urandom_range(0, MemWords - 1));
      else             addr = Base + 32'(4 * $urandom_range(0, 15));
      load_we    = ($urandom_range(0, 5) == 0);
      load_addr  = 10'($urandom_range(0, 15));
      load_wdata = $urandom;
      tick();
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
